dispense_controller: RTL
========================

DISPENSE_CONTROLLER -- requirements
Module: dispense_controller

Interface
REQ-001 Parameter PULSE_CYC, default 8: solenoid on-time in clk cycles, legal range 1..255.
REQ-002 Parameter GAP_CYC, default 4: mandatory idle cycles after each actuation, legal range 1..255.
REQ-003 Parameter TIMEOUT_CYC, default 64: maximum cycles to wait for a drop-sensor acknowledge, legal range 1..1023.
REQ-004 Parameter DEPTH, default 4: request queue depth, power of two, minimum 2.
REQ-005 clk  input  1  the single clock; all logic runs on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 out  input  1  product-dispense request from the vend FSM.
REQ-008 change  input  2  change request: 00 none, 01 one 5-unit coin, 10 one 10-unit coin, 11 illegal.
REQ-009 prod_sense  input  1  product drop sensor, asynchronous to clk, active-high.
REQ-010 coin_sense  input  1  coin drop sensor, asynchronous to clk, active-high.
REQ-011 fault_clr  input  1  single-cycle strobe that clears a fault.
REQ-012 prod_sol  output  1  product solenoid drive.
REQ-013 coin5_sol  output  1  5-unit coin solenoid drive.
REQ-014 coin10_sol  output  1  10-unit coin solenoid drive.
REQ-015 busy  output  1  high when the queue is non-empty or the FSM is not in IDLE.
REQ-016 fault  output  1  sticky flag: acknowledge timeout.
REQ-017 ovf  output  1  sticky flag: request dropped because the queue was full.

Function
REQ-018 Every cycle with out=1 or change in {01,10} SHALL push one entry {out, change} into the queue.
- change=11 with out=0: no push.
- change=11 with out=1: push with change forced to 00.
REQ-019 A push while the queue is full, with no pop in the same cycle, SHALL drop the request and set ovf.
REQ-020 A simultaneous push and pop on a full queue SHALL accept the push.
REQ-021 prod_sense and coin_sense SHALL each pass through a 2-flop synchronizer; an acknowledge is a rising edge of the synchronized signal.
REQ-022 FSM states SHALL be IDLE, LOAD, PULSE, WAIT_ACK, GAP and FAULT.
REQ-023 IDLE: if the queue is non-empty, pop the head into the current-entry register and go to LOAD next cycle.
REQ-024 LOAD: select the next pending item in the current entry (product first, then coin) and go to PULSE; if no item is pending, go to IDLE.
REQ-025 PULSE: the selected solenoid SHALL be high for exactly PULSE_CYC consecutive cycles, then the FSM goes to WAIT_ACK; only one solenoid is ever high at a time.
REQ-026 WAIT_ACK: an acknowledge on the matching sensor SHALL clear that item and go to GAP.
- If no acknowledge arrives within TIMEOUT_CYC cycles, go to FAULT and set fault.
- Acknowledges arriving in PULSE are ignored.
REQ-027 GAP: hold all solenoids low for GAP_CYC cycles, then go to LOAD.
REQ-028 FAULT: all solenoids low; the queue keeps accepting pushes.
- On fault_clr, clear fault, discard the current entry and go to IDLE.
- fault_clr in any other state is ignored; ovf is cleared only by reset.
REQ-029 Latency: the first solenoid SHALL rise 3 cycles after the push cycle when the FSM is idle and the queue is empty.
REQ-030 Queue pointers SHALL wrap modulo DEPTH; the counters SHALL be sized from the parameters and SHALL never wrap mid-count.

Reset
REQ-031 While rst_n=0, all of the following SHALL be 0: prod_sol, coin5_sol, coin10_sol, busy, fault, ovf, the queue pointers, the synchronizers and the counters; the FSM SHALL be in IDLE.
REQ-032 Reset asserted mid-PULSE SHALL drop the solenoid asynchronously; the in-flight entry and all queued entries SHALL be lost.
REQ-033 Release of rst_n SHALL be synchronized to clk so that the first active edge is clean.

Structure
REQ-034 The shared package vend_pkg SHALL hold the change codes (NONE, C5, C10), the FSM state enum and the queue-entry width (3).
REQ-035 The queue SHALL be the sub-module dispense_fifo (parameterized DEPTH, width 3, full/empty outputs).
- The FSM, synchronizers and counters SHALL remain in dispense_controller.

Verification
REQ-036 Push out=1, change=00; pulse prod_sense 5 cycles after prod_sol falls -> prod_sol high 8 cycles starting 3 cycles after the push, then GAP of 4 cycles, busy falls, fault=0.
REQ-037 Push out=1, change=10 -> prod_sol pulse, ack, gap, then coin10_sol pulse of 8 cycles; coin5_sol stays 0 throughout.
REQ-038 Push out=0, change=01 with coin_sense never rising -> fault rises 64 cycles after coin5_sol falls; a subsequent fault_clr -> fault=0, FSM in IDLE.
REQ-039 6 consecutive pushes with no acknowledges and DEPTH=4 -> ovf=1, exactly 4 entries queued plus 1 in service; the 6th push is dropped.
REQ-040 Assert rst_n=0 in cycle 3 of a PULSE -> solenoid drops asynchronously, busy=0; after release, no stale request is replayed.
REQ-041 A cycle with change=11 and out=0 -> no push, busy stays 0; a cycle with change=11 and out=1 -> product pulse only.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense path: change codes, FSM states
// and the packed request entry carried through the dispense queue.
package vend_pkg;

    localparam int ENTRY_W = 3;

    localparam logic [1:0] NONE    = 2'b00;
    localparam logic [1:0] C5      = 2'b01;
    localparam logic [1:0] C10     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PULSE    = 3'd2,
        WAIT_ACK = 3'd3,
        GAP      = 3'd4,
        FAULT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_PROD = 2'd0,
        SEL_C5   = 2'd1,
        SEL_C10  = 2'd2
    } sel_t;

    typedef struct packed {
        logic       prod;
        logic [1:0] chg;
    } entry_t;

    // An illegal change code riding along with a product request is dropped to NONE.
    function automatic logic [ENTRY_W-1:0] make_entry(input logic o, input logic [1:0] c);
        logic [1:0] c_fixed;
        if (c == ILLEGAL) begin
            c_fixed = NONE;
        end else begin
            c_fixed = c;
        end
        return {o, c_fixed};
    endfunction

endpackage

// File: rtl/dispense_fifo.sv
// Request queue for the dispense controller: DEPTH entries, registered
// pointers and occupancy count, push accepted on full when a pop coincides.
module dispense_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == '0);
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);
    assign rdata   = mem_r[rd_ptr_r];

    // Storage, pointers (wrap naturally at the power-of-two depth) and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dispense_controller.sv
// Product/coin solenoid sequencer: queues requests, pulses one solenoid at a
// time, waits for the drop-sensor acknowledge and flags timeouts and overflow.
module dispense_controller
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 8,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out,
    input  logic [1:0] change,
    input  logic       prod_sense,
    input  logic       coin_sense,
    input  logic       fault_clr,
    output logic       prod_sol,
    output logic       coin5_sol,
    output logic       coin10_sol,
    output logic       busy,
    output logic       fault,
    output logic       ovf
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC)
                           ? ((PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC)
                           : ((GAP_CYC   > TIMEOUT_CYC) ? GAP_CYC   : TIMEOUT_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]         rst_sync_r;
    logic               rst_int_n;
    logic [2:0]         prod_sync_r;
    logic [2:0]         coin_sync_r;
    logic               prod_ack_s;
    logic               coin_ack_s;
    logic               item_ack_s;
    logic               push_req_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] push_data_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    state_t             state_r;
    sel_t               sel_r;
    entry_t             cur_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               prod_sol_r;
    logic               coin5_sol_r;
    logic               coin10_sol_r;
    logic               busy_r;
    logic               fault_r;
    logic               ovf_r;

    // Reset asserts asynchronously but releases only on a clean clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_r[1];

    // Two-flop synchronizers plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            prod_sync_r <= 3'b000;
            coin_sync_r <= 3'b000;
        end else begin
            prod_sync_r <= {prod_sync_r[1:0], prod_sense};
            coin_sync_r <= {coin_sync_r[1:0], coin_sense};
        end
    end
    assign prod_ack_s = prod_sync_r[1] & ~prod_sync_r[2];
    assign coin_ack_s = coin_sync_r[1] & ~coin_sync_r[2];

    // Route the acknowledge that matches the item currently being dispensed.
    always_comb begin
        item_ack_s = 1'b0;
        case (sel_r)
            SEL_PROD: item_ack_s = prod_ack_s;
            SEL_C5:   item_ack_s = coin_ack_s;
            SEL_C10:  item_ack_s = coin_ack_s;
            default:  item_ack_s = 1'b0;
        endcase
    end

    assign push_req_s  = out | (change == C5) | (change == C10);
    assign push_data_s = make_entry(out, change);
    assign pop_s       = (state_r == IDLE) && !fifo_empty_s;

    dispense_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_int_n),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata (push_data_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky overflow: a push that meets a full queue without a same-cycle pop.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ovf_r <= 1'b0;
        end else if (push_req_s && fifo_full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Dispense FSM; busy is computed from the next state so it tracks without lag.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_r      <= IDLE;
            sel_r        <= SEL_PROD;
            cur_r        <= '0;
            cnt_r        <= '0;
            prod_sol_r   <= 1'b0;
            coin5_sol_r  <= 1'b0;
            coin10_sol_r <= 1'b0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        cur_r   <= fifo_rdata_s;
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= push_req_s;
                    end
                end
                LOAD: begin
                    cnt_r <= PULSE_LD;
                    if (cur_r.prod) begin
                        sel_r      <= SEL_PROD;
                        prod_sol_r <= 1'b1;
                        state_r    <= PULSE;
                        busy_r     <= 1'b1;
                    end else if (cur_r.chg == C5) begin
                        sel_r       <= SEL_C5;
                        coin5_sol_r <= 1'b1;
                        state_r     <= PULSE;
                        busy_r      <= 1'b1;
                    end else if (cur_r.chg == C10) begin
                        sel_r        <= SEL_C10;
                        coin10_sol_r <= 1'b1;
                        state_r      <= PULSE;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= push_req_s | ~fifo_empty_s;
                    end
                end
                PULSE: begin
                    busy_r <= 1'b1;
                    if (cnt_r == '0) begin
                        prod_sol_r   <= 1'b0;
                        coin5_sol_r  <= 1'b0;
                        coin10_sol_r <= 1'b0;
                        cnt_r        <= TMO_LD;
                        state_r      <= WAIT_ACK;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WAIT_ACK: begin
                    busy_r <= 1'b1;
                    if (item_ack_s) begin
                        if (sel_r == SEL_PROD) begin
                            cur_r.prod <= 1'b0;
                        end else begin
                            cur_r.chg <= NONE;
                        end
                        cnt_r   <= GAP_LD;
                        state_r <= GAP;
                    end else if (cnt_r == '0) begin
                        fault_r <= 1'b1;
                        state_r <= FAULT;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                GAP: begin
                    busy_r <= 1'b1;
                    if (cnt_r == '0) begin
                        state_r <= LOAD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault_r <= 1'b0;
                        cur_r   <= '0;
                        state_r <= IDLE;
                        busy_r  <= push_req_s | ~fifo_empty_s;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    prod_sol_r   <= 1'b0;
                    coin5_sol_r  <= 1'b0;
                    coin10_sol_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign prod_sol   = prod_sol_r;
    assign coin5_sol  = coin5_sol_r;
    assign coin10_sol = coin10_sol_r;
    assign busy       = busy_r;
    assign fault      = fault_r;
    assign ovf        = ovf_r;

endmodule
